// File: rtl/layer_sched.sv
// layer_sched: frame-synchronous commit of per-layer enable/blink settings for the compositor.
// Blink counters and phase registers exist only when LAYER_SCHED_BLINK_EN is defined.
module layer_sched #(
  parameter int NUM_LAYERS = 4,
  parameter int BLINK_W = 6,
  localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LW-1:0]         cfg_layer,
  input  logic                  cfg_enable,
  input  logic [BLINK_W-1:0]    cfg_blink_period,
  output logic                  cfg_pending,
  output logic [NUM_LAYERS-1:0] layer_en
);
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  state_t state, state_nx;
  logic wr, commit;
  logic [NUM_LAYERS-1:0] shadow_en, active_en;
  // writes to nonexistent layers are swallowed without marking anything pending
  assign wr = cfg_valid && cfg_ready && int'(cfg_layer) < NUM_LAYERS;
  assign commit = frame_start && state != COMMIT && (cfg_pending || wr);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb state_nx = commit ? COMMIT : state == COMMIT ? IDLE : wr ? PENDING : state;
  always_comb begin
    cfg_ready = state != COMMIT;
    cfg_pending = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      shadow_en <= NUM_LAYERS'(1);
      active_en <= NUM_LAYERS'(1);
    end else begin
      if (wr) shadow_en[cfg_layer] <= cfg_enable;
      if (state == COMMIT) active_en <= shadow_en;
    end
`ifdef LAYER_SCHED_BLINK_EN
  logic [BLINK_W-1:0] shadow_period [NUM_LAYERS];
  logic [BLINK_W-1:0] period [NUM_LAYERS];
  logic [BLINK_W-1:0] cnt [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] dirty, phase;
  always_ff @(posedge clk)
    if (rst) dirty <= '0;
    else if (wr) dirty[cfg_layer] <= 1'b1;
    else if (state == COMMIT) dirty <= '0;
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NUM_LAYERS; i++) shadow_period[i] <= '0;
    else if (wr) shadow_period[cfg_layer] <= cfg_blink_period;
  // non-dirty layers keep blinking through a commit; dirty ones restart in phase
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_LAYERS; i++)
      if (rst) begin
        period[i] <= '0;
        cnt[i] <= '0;
        phase[i] <= 1'b1;
      end else begin
        if (state == COMMIT) period[i] <= shadow_period[i];
        if ((state == COMMIT && dirty[i]) || !active_en[i] || period[i] == '0) begin
          cnt[i] <= '0;
          phase[i] <= 1'b1;
        end else if (frame_start) begin
          cnt[i] <= cnt[i] == period[i] - BLINK_W'(1) ? '0 : cnt[i] + BLINK_W'(1);
          if (cnt[i] == period[i] - BLINK_W'(1)) phase[i] <= ~phase[i];
        end
      end
  assign layer_en = active_en & phase;
`else
  logic unused_period;
  assign unused_period = ^cfg_blink_period;
  assign layer_en = active_en;
`endif
endmodule
